// File: rtl/fp32_div_pipe.sv
// fp32_div_pipe: four-stage valid/ready binary32 divider computing a * (1/b),
// with round-to-nearest-even packing and IEEE special-case resolution.

module fp32_recip #(
  parameter logic [31:0] QNAN = 32'h7FC00001
) (
  input  logic [30:0] mag_i,
  output logic [30:0] mag_o
);
  localparam logic [47:0] OneQ47 = 48'h8000_0000_0000;

  logic [7:0]  e;
  logic [22:0] m;
  logic [22:0] qm;
  logic [8:0]  re;

  // Truncating reciprocal of the magnitude; a pure power of two has qm == 0.
  always_comb begin
    e     = mag_i[30:23];
    m     = mag_i[22:0];
    qm    = 23'(OneQ47 / {24'd0, 1'b1, m});
    re    = ((m == 23'd0) ? 9'd254 : 9'd253) - {1'b0, e};
    mag_o = {re[7:0], qm};
    if (e == 8'hFF) begin
      mag_o = (m != 23'd0) ? QNAN[30:0] : 31'd0;
    end else if (e == 8'd0) begin
      mag_o = {8'hFF, 23'd0};
    end else if (re[8] || (re == 9'd0)) begin
      mag_o = 31'd0;
    end
  end
endmodule

module fp32_div_pipe #(
  parameter logic [31:0] QNAN         = 32'h7FC00001,
  parameter int unsigned FLUSH_DENORM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_q,
  output logic [3:0]  out_flags
);
  localparam int unsigned ProdW = 48;
  localparam int unsigned ExpW  = 10;

  // Class vector layout: {nan, inf, zero}
  function automatic logic [2:0] classify(input logic [30:0] x);
    logic nan, inf, zero;
    nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    zero = (x[30:23] == 8'd0) && ((FLUSH_DENORM != 0) || (x[22:0] == 23'd0));
    return {nan, inf, zero};
  endfunction

  logic adv;

  logic        s0_valid_q, s1_valid_q, s2_valid_q, out_valid_q;
  logic [30:0] s0_a_q, s0_b_q, s1_a_q, s1_r_q;
  logic        s0_sign_q, s1_sign_q, s2_sign_q;
  logic [2:0]  s0_acls_q, s0_bcls_q, s1_acls_q, s1_bcls_q, s2_acls_q, s2_bcls_q;
  logic        s2_rinf_q, s2_rzero_q;
  logic [ProdW-1:0]       s2_p_q, s2_p_d;
  logic signed [ExpW-1:0] s2_e_q, s2_e_d;
  logic [31:0] out_q_q, q_d;
  logic [3:0]  out_flags_q, flags_d;

  logic [30:0] recip_in_c, recip_out_c;
  logic [23:0] ma_c, mr_c;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_q     = out_q_q;
  assign out_flags = out_flags_q;

  // Subnormal divisors enter the reciprocal as exact zero.
  assign recip_in_c = {s0_b_q[30:23], (s0_b_q[30:23] == 8'd0) ? 23'd0 : s0_b_q[22:0]};

  fp32_recip #(.QNAN(QNAN)) u_recip (
    .mag_i (recip_in_c),
    .mag_o (recip_out_c)
  );

  always_comb begin
    ma_c   = {1'b1, s1_a_q[22:0]};
    mr_c   = {1'b1, s1_r_q[22:0]};
    s2_p_d = ProdW'(ma_c) * ProdW'(mr_c);
    s2_e_d = $signed(ExpW'(s1_a_q[30:23])) + $signed(ExpW'(s1_r_q[30:23])) - 10'sd127;
  end

  logic [22:0]            mant_c;
  logic                   guard_c, sticky_c, rnd_c;
  logic [23:0]            sum_c;
  logic signed [ExpW-1:0] exp_pre_c, exp_rnd_c;

  // S3: normalise, round, then let the special-case priority override.
  always_comb begin
    q_d     = 32'd0;
    flags_d = 4'd0;
    if (s2_p_q[47]) begin
      mant_c    = s2_p_q[46:24];
      guard_c   = s2_p_q[23];
      sticky_c  = |s2_p_q[22:0];
      exp_pre_c = s2_e_q + 10'sd1;
    end else begin
      mant_c    = s2_p_q[45:23];
      guard_c   = s2_p_q[22];
      sticky_c  = |s2_p_q[21:0];
      exp_pre_c = s2_e_q;
    end
    rnd_c     = guard_c && (sticky_c || mant_c[0]);
    sum_c     = {1'b0, mant_c} + 24'(rnd_c);
    exp_rnd_c = exp_pre_c + $signed(ExpW'(sum_c[23]));

    if (exp_rnd_c >= 10'sd255) begin
      q_d     = {s2_sign_q, 8'hFF, 23'd0};
      flags_d = 4'b0010;
    end else if (exp_rnd_c <= 10'sd0) begin
      q_d     = {s2_sign_q, 31'd0};
      flags_d = 4'b0001;
    end else begin
      q_d     = {s2_sign_q, exp_rnd_c[7:0], sum_c[22:0]};
    end

    if (s2_acls_q[2] || s2_bcls_q[2]) begin
      q_d     = QNAN;
      flags_d = 4'b0000;
    end else if (s2_acls_q[1] && s2_bcls_q[1]) begin
      q_d     = QNAN;
      flags_d = 4'b1000;
    end else if (s2_acls_q[0] && s2_bcls_q[0]) begin
      q_d     = QNAN;
      flags_d = 4'b1000;
    end else if (s2_acls_q[1]) begin
      q_d     = {s2_sign_q, 8'hFF, 23'd0};
      flags_d = 4'b0000;
    end else if (s2_bcls_q[0]) begin
      q_d     = {s2_sign_q, 8'hFF, 23'd0};
      flags_d = 4'b0100;
    end else if (s2_acls_q[0] || s2_bcls_q[1]) begin
      q_d     = {s2_sign_q, 31'd0};
      flags_d = 4'b0000;
    end else if (s2_rinf_q) begin
      q_d     = {s2_sign_q, 8'hFF, 23'd0};
      flags_d = 4'b0010;
    end else if (s2_rzero_q) begin
      q_d     = {s2_sign_q, 31'd0};
      flags_d = 4'b0001;
    end
  end

  // Control and output registers: the only state that reset must clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_valid_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q_q     <= 32'd0;
      out_flags_q <= 4'd0;
    end else if (adv) begin
      s0_valid_q  <= in_valid;
      s1_valid_q  <= s0_valid_q;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_q_q     <= q_d;
        out_flags_q <= flags_d;
      end
    end
  end

  // Datapath registers; contents behind a clear valid bit are don't-care.
  always_ff @(posedge clk) begin
    if (adv) begin
      s0_a_q     <= in_a[30:0];
      s0_b_q     <= in_b[30:0];
      s0_sign_q  <= in_a[31] ^ in_b[31];
      s0_acls_q  <= classify(in_a[30:0]);
      s0_bcls_q  <= classify(in_b[30:0]);

      s1_a_q     <= s0_a_q;
      s1_r_q     <= recip_out_c;
      s1_sign_q  <= s0_sign_q;
      s1_acls_q  <= s0_acls_q;
      s1_bcls_q  <= s0_bcls_q;

      s2_p_q     <= s2_p_d;
      s2_e_q     <= s2_e_d;
      s2_sign_q  <= s1_sign_q;
      s2_acls_q  <= s1_acls_q;
      s2_bcls_q  <= s1_bcls_q;
      s2_rinf_q  <= (s1_r_q[30:23] == 8'hFF) && (s1_r_q[22:0] == 23'd0);
      s2_rzero_q <= (s1_r_q[30:23] == 8'd0);
    end
  end
endmodule

// File: tb/tb_fp32_div_pipe.sv
// tb_fp32_div_pipe: directed and streamed checks of fp32_div_pipe results,
// latency, backpressure and reset behaviour.
module tb_fp32_div_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_q;
  logic [3:0]  out_flags;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] got_q[$];
  logic [3:0]  got_f[$];
  int          got_c[$];

  fp32_div_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A transfer happens at the next rising edge when both are high here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_q.push_back(out_q);
      got_f.push_back(out_flags);
      got_c.push_back(cyc);
    end
  end

  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic [63:0] d;
    logic [23:0] m;
    int          e;
    d = $realtobits(v);
    e = int'(d[62:52]) - 1023 + 127;
    m = {1'b0, d[51:29]};
    if (d[28] && ((|d[27:0]) || m[0])) m = m + 24'd1;
    if (m[23]) begin
      m = 24'd0;
      e = e + 1;
    end
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] rand_normal();
    return {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
  endfunction

  task automatic clear_results();
    got_q.delete();
    got_f.delete();
    got_c.delete();
  endtask

  task automatic send_op(input logic [31:0] a, input logic [31:0] b, output int acc, output bit ok);
    ok       = 1'b0;
    acc      = -1;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok  = 1'b1;
        acc = cyc;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound && !ok; k++) begin
      if (got_q.size() >= n) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (got_q.size() >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++;
    if (out_q !== 32'd0) begin n_fail++; $display("FAIL reset_out_q got %h want 00000000", out_q); end
    n_checks++;
    if (out_flags !== 4'd0) begin n_fail++; $display("FAIL reset_out_flags got %b want 0000", out_flags); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int    acc;
    bit    ok;
    longint d;
    clear_results();
    out_ready = 1'b1;
    send_op(32'h40C00000, 32'h40000000, acc, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_accept timed out"); end
    wait_results(1, 20, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL single_result timed out, got %0d results want 1", got_q.size());
    end else begin
      n_checks++;
      if (got_c[0] - acc != 4) begin n_fail++; $display("FAIL single_latency got %0d want 4", got_c[0] - acc); end
      d = longint'(got_q[0]) - longint'(32'h40400000);
      n_checks++;
      if (d > 2 || d < -2) begin n_fail++; $display("FAIL single_q got %h want 40400000 +/-2ulp", got_q[0]); end
      n_checks++;
      if (got_f[0] !== 4'd0) begin n_fail++; $display("FAIL single_flags got %b want 0000", got_f[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta[100];
    logic [31:0] tb[100];
    logic [31:0] te[100];
    int          ready_bad;
    bit          ok;
    longint      d;
    clear_results();
    out_ready = 1'b1;
    ready_bad = 0;
    for (int i = 0; i < 100; i++) begin
      ta[i] = rand_normal();
      tb[i] = rand_normal();
      te[i] = r2f(f2r(ta[i]) / f2r(tb[i]));
    end
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_a     = ta[i];
      in_b     = tb[i];
      @(negedge clk);
      if (in_ready !== 1'b1) ready_bad++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (ready_bad != 0) begin n_fail++; $display("FAIL b2b_in_ready low in %0d cycles want 0", ready_bad); end
    wait_results(100, 40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL b2b_count got %0d results want 100", got_q.size());
    end else begin
      for (int i = 0; i < 100; i++) begin
        d = longint'(got_q[i]) - longint'(te[i]);
        n_checks++;
        if (d > 2 || d < -2) begin
          n_fail++;
          $display("FAIL b2b_q[%0d] %h/%h got %h want %h +/-2ulp", i, ta[i], tb[i], got_q[i], te[i]);
        end
        n_checks++;
        if (got_f[i] !== 4'd0) begin n_fail++; $display("FAIL b2b_flags[%0d] got %b want 0000", i, got_f[i]); end
        n_checks++;
        if (got_c[i] != got_c[0] + i) begin
          n_fail++; $display("FAIL b2b_rate[%0d] got cycle %0d want %0d", i, got_c[i], got_c[0] + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ta[4] = '{32'h40C00000, 32'h3F800000, 32'h41200000, 32'hC0E00000};
    logic [31:0] tb[4] = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h3F000000};
    logic [31:0] te[4] = '{32'h40400000, 32'h3F000000, 32'h40A00000, 32'hC1600000};
    bit ok;
    bit seen;
    clear_results();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_a     = ta[i];
      in_b     = tb[i];
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_fill_ready[%0d] got %b want 1", i, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL bp_first_valid timed out");
    end else begin
      for (int j = 0; j < 5; j++) begin
        if (j > 0) begin
          @(posedge clk); #1;
          @(negedge clk);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready[%0d] got %b want 0", j, in_ready); end
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall_valid[%0d] got %b want 1", j, out_valid); end
        n_checks++;
        if (out_q !== te[0]) begin n_fail++; $display("FAIL bp_stall_q[%0d] got %h want %h", j, out_q, te[0]); end
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_results(4, 20, ok);
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() != 4) begin
      n_fail++; $display("FAIL bp_drain_count got %0d want 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got_q[i] !== te[i]) begin n_fail++; $display("FAIL bp_drain_q[%0d] got %h want %h", i, got_q[i], te[i]); end
        n_checks++;
        if (got_f[i] !== 4'd0) begin n_fail++; $display("FAIL bp_drain_flags[%0d] got %b want 0000", i, got_f[i]); end
      end
    end
  endtask

  task automatic test_specials();
    logic [31:0] ta[7] = '{32'h3F800000, 32'h80000000, 32'h7F800000, 32'h7FC00000,
                           32'h40400000, 32'hFF800000, 32'hBF800000};
    logic [31:0] tb[7] = '{32'h00000000, 32'h00000000, 32'hFF800000, 32'h3F800000,
                           32'h7F800000, 32'h40000000, 32'h00000000};
    logic [31:0] te[7] = '{32'h7F800000, 32'h7FC00001, 32'h7FC00001, 32'h7FC00001,
                           32'h00000000, 32'hFF800000, 32'hFF800000};
    logic [3:0]  tf[7] = '{4'b0100, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    bit ok;
    clear_results();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_a     = ta[i];
      in_b     = tb[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_results(7, 20, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL spec_count got %0d want 7", got_q.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_checks++;
        if (got_q[i] !== te[i]) begin
          n_fail++; $display("FAIL spec_q[%0d] %h/%h got %h want %h", i, ta[i], tb[i], got_q[i], te[i]);
        end
        n_checks++;
        if (got_f[i] !== tf[i]) begin
          n_fail++; $display("FAIL spec_flags[%0d] %h/%h got %b want %b", i, ta[i], tb[i], got_f[i], tf[i]);
        end
      end
    end
  endtask

  task automatic test_range();
    logic [31:0] ta[3] = '{32'h7F000000, 32'h00800000, 32'h3F800000};
    logic [31:0] tb[3] = '{32'h3E800000, 32'h40800000, 32'h00000001};
    logic [31:0] te[3] = '{32'h7F800000, 32'h00000000, 32'h7F800000};
    logic [3:0]  tf[3] = '{4'b0010, 4'b0001, 4'b0100};
    bit ok;
    clear_results();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = ta[i];
      in_b     = tb[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_results(3, 20, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL range_count got %0d want 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got_q[i] !== te[i]) begin
          n_fail++; $display("FAIL range_q[%0d] %h/%h got %h want %h", i, ta[i], tb[i], got_q[i], te[i]);
        end
        n_checks++;
        if (got_f[i] !== tf[i]) begin
          n_fail++; $display("FAIL range_flags[%0d] %h/%h got %b want %b", i, ta[i], tb[i], got_f[i], tf[i]);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    int acc;
    bit ok;
    clear_results();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = 32'h41000000;
      in_b     = 32'h40800000;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_flight_valid got %b want 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_flight_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL rst_flight_stale got %0d results want 0", got_q.size()); end
    send_op(32'h3F800000, 32'h40000000, acc, ok);
    wait_results(1, 20, ok);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL rst_flight_after_count got %0d want 1", got_q.size());
    end else begin
      n_checks++;
      if (got_q[0] !== 32'h3F000000) begin n_fail++; $display("FAIL rst_flight_after_q got %h want 3F000000", got_q[0]); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_specials();
    test_range();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fp32_div_pipe.md
Name: fp32_div_pipe

Overview:
- Pipelined single-precision divider q = a / b, built as reciprocal-then-multiply.
- Registers b, drives it into the existing combinational fp32_recip block, then multiplies a by 1/b.
- Rounds, packs and resolves IEEE special cases.
- Sits directly downstream of fp32_recip. Feeds the FPU result mux over a valid/ready stream interface.

Parameters:
- QNAN, 32'h7FC00001, canonical quiet-NaN pattern emitted; matches fp32_recip.
- FLUSH_DENORM, 1, subnormal inputs are treated as signed zero (only value 1 is supported).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair this cycle
- in_a  input  32  dividend, IEEE-754 binary32
- in_b  input  32  divisor, IEEE-754 binary32
- out_valid  output  1  quotient valid
- out_ready  input  1  downstream accepts quotient
- out_q  output  32  quotient, IEEE-754 binary32
- out_flags  output  4  {invalid, div_by_zero, overflow, underflow}, qualified by out_valid

Behaviour:
- Clock and reset: one clock clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 sampled at clk edge):
  - All stage valid bits clear, out_valid=0, out_q=0, out_flags=0.
  - in_ready=1 from the first cycle after reset.
  - A reset mid-operation discards all in-flight operations; nothing is emitted for them.
- Pipeline: 4 register stages S0..S3. Latency is 4 cycles from an accepted input (in_valid&in_ready) to out_valid, absent stalls.
  - S0: register a, b, sign_q = a[31]^b[31]. Classify each operand as nan / inf / zero / normal; subnormal counts as zero.
  - S1: drive {b[31], b[30:23], 0 mantissa if subnormal else b[22:0]} into an fp32_recip instance. Register the reciprocal r, plus a and the class flags.
  - S2: form mantissas ma = {1,a[22:0]} and mr = {1,r[22:0]}. Register the 48-bit product p = ma*mr and the 10-bit signed exponent e = ea + er - 127.
  - S3:
    - If p[47]=1, take mantissa p[46:24], with guard p[23] and sticky |p[22:0]; exponent is e+1.
    - Otherwise take p[45:23], with guard p[22] and sticky |p[21:0]; exponent is e.
    - Round to nearest even.
    - A mantissa carry-out increments the exponent.
    - Exponent >= 255 after rounding: signed infinity, overflow=1.
    - Exponent <= 0: signed zero, underflow=1.
    - Register out_q and out_flags.
- Special-case priority, evaluated from S0 class flags (never from r), first match wins:
  1. a or b NaN -> QNAN, invalid=0.
  2. a inf and b inf -> QNAN, invalid=1.
  3. a zero and b zero -> QNAN, invalid=1.
  4. a inf -> {sign_q, inf}.
  5. b zero -> {sign_q, inf}, div_by_zero=1.
  6. a zero or b inf -> {sign_q, zero}.
  7. r inf or r zero (recip overflow/underflow) -> {sign_q, inf} with overflow=1, or {sign_q, zero} with underflow=1, respectively.
  8. Otherwise use the S3 arithmetic result.
- Handshake:
  - Global advance: adv = !out_valid | out_ready. All stages shift only when adv=1.
  - in_ready = adv. Bubbles propagate as valid=0.
  - out_valid=1 with out_ready=0 holds out_q, out_flags and every stage stable; in_ready=0 that cycle.
  - Simultaneous output accept and input accept in the same cycle is allowed: full throughput of 1 operation per cycle.
  - in_a and in_b are ignored when in_valid=0 or in_ready=0.
- Accuracy: fp32_recip truncates, so normal-range results are within 2 ulp of the correctly rounded quotient. Special-case results are exact bit patterns.
- Ordering: results emerge strictly in acceptance order; no reordering, no drops.

Test Plan:
- Reset then a single op: a=0x40C00000 (6.0), b=0x40000000 (2.0) -> out_valid exactly 4 cycles after acceptance, out_q within 2 ulp of 0x40400000, flags=0.
- Back-to-back stream of 100 random normal pairs with out_ready=1 -> in_ready stays 1, one result per cycle, order preserved, each result within 2 ulp of the reference model.
- Backpressure: out_ready=0 for 5 cycles while 4 ops are in flight -> in_ready=0, out_q stable; on release, results drain in order with no loss or duplication.
- Specials:
  - 1.0/0.0 -> 0x7F800000, div_by_zero=1.
  - -0.0/0.0 -> 0x7FC00001, invalid=1.
  - inf/-inf -> 0x7FC00001, invalid=1.
  - 0x7FC00000/1.0 -> 0x7FC00001, invalid=0.
  - 3.0/inf -> 0x00000000.
  - -inf/2.0 -> 0xFF800000.
- Range limits:
  - 0x7F000000 / 0x3E800000 (2^127 / 0.25) -> 0x7F800000, overflow=1.
  - 0x00800000 / 0x40800000 (min normal / 4) -> 0x00000000, underflow=1.
  - Subnormal b=0x00000001 with a=1.0 -> 0x7F800000, div_by_zero=1.
- Reset asserted with 3 ops in flight -> the next cycle shows out_valid=0 and in_ready=1, and no stale results appear afterwards.
